// File: rtl/halt_dump_ctrl_if.sv
// rtl/halt_dump_ctrl_if.sv - CPU-side and dump-side signal bundle for halt_dump_ctrl
//
// Purpose: groups the fetch-stage taps, pipeline control, MainMemory
// ownership and the dump stream of the run/halt sequencer.
// Modports:
//   master - the sequencer (drives PCHold, FetchKill, PipeEN, MemOwner,
//            DumpAddr, DumpValid, DumpData, DumpIndex, Done, CycleCount)
//   slave  - the CPU / memory / dump sink side (drives Inst_F,
//            BranchTaken_D, MemReadData, DumpReady)
interface halt_dump_ctrl_if #(
  parameter int ADDR_W = 9,
  parameter int CYC_W  = 32
);
  logic [31:0]       Inst_F;
  logic              BranchTaken_D;
  logic              PCHold;
  logic              FetchKill;
  logic              PipeEN;
  logic              MemOwner;
  logic [ADDR_W-1:0] DumpAddr;
  logic [31:0]       MemReadData;
  logic              DumpValid;
  logic              DumpReady;
  logic [31:0]       DumpData;
  logic [ADDR_W-1:0] DumpIndex;
  logic              Done;
  logic [CYC_W-1:0]  CycleCount;

  modport master (
    input  Inst_F, BranchTaken_D, MemReadData, DumpReady,
    output PCHold, FetchKill, PipeEN, MemOwner, DumpAddr,
           DumpValid, DumpData, DumpIndex, Done, CycleCount
  );

  modport slave (
    output Inst_F, BranchTaken_D, MemReadData, DumpReady,
    input  PCHold, FetchKill, PipeEN, MemOwner, DumpAddr,
           DumpValid, DumpData, DumpIndex, Done, CycleCount
  );
endinterface

// File: rtl/halt_dump_ctrl.sv
// rtl/halt_dump_ctrl.sv - run/halt sequencer with pipeline drain and data-memory dump
//
// Purpose: detects the halt word in fetch, freezes the PC and feeds bubbles
// into IF/ID, lets the downstream stages drain for DRAIN_CYCLES cycles, then
// takes MainMemory and streams every data word out before raising Done.
// Ports:
//   CLOCK - system clock, rising edge
//   RESET - asynchronous active-high reset
//   bus   - halt_dump_ctrl_if.master (fetch taps, pipeline control,
//           memory ownership, dump stream, Done, CycleCount)
// Configuration macro: DUMP_EN. When undefined the dump states are not
// built, DRAIN goes straight to DONE and all dump outputs are tied to 0.
module halt_dump_ctrl #(
  parameter logic [31:0] HALT_WORD    = 32'hFFFF_FFFF,
  parameter int          DRAIN_CYCLES = 4,
  parameter int          MEM_DEPTH    = 512,
  parameter int          ADDR_W       = 9,
  parameter int          CYC_W        = 32
) (
  input logic             CLOCK,
  input logic             RESET,
  halt_dump_ctrl_if.master bus
);

  localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    RUN, DRAIN, DUMP_ADDR, DUMP_CAP, DUMP_OUT, DONE
  } state_t;

  state_t           state, state_nxt;
  logic [DCW-1:0]   drain_cnt;
  logic [CYC_W-1:0] cyc_cnt;
  logic             halt;
  logic             pc_hold, pipe_en, mem_owner, dump_valid, done;

  // A halt word alongside a taken branch is a wrong-path fetch.
  assign halt = (bus.Inst_F == HALT_WORD) && !bus.BranchTaken_D;

`ifdef DUMP_EN
  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(MEM_DEPTH - 1);
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] dump_index;
  logic [31:0]       dump_data;
`endif

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) state <= RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    pc_hold    = 1'b1;
    pipe_en    = 1'b0;
    mem_owner  = 1'b0;
    dump_valid = 1'b0;
    done       = 1'b0;
    case (state)
      RUN: begin
        // Combinational hold keeps the halt word out of IF/ID and the PC
        // from advancing in the detection cycle; forced low while in reset.
        pc_hold = halt && !RESET;
        pipe_en = 1'b1;
        if (halt) state_nxt = DRAIN;
      end
      DRAIN: begin
        pipe_en = 1'b1;
        if (drain_cnt == DRAIN_LAST) begin
`ifdef DUMP_EN
          state_nxt = DUMP_ADDR;
`else
          state_nxt = DONE;
`endif
        end
      end
`ifdef DUMP_EN
      DUMP_ADDR: begin
        mem_owner = 1'b1;
        state_nxt = DUMP_CAP;
      end
      DUMP_CAP: begin
        mem_owner = 1'b1;
        state_nxt = DUMP_OUT;
      end
      DUMP_OUT: begin
        mem_owner  = 1'b1;
        dump_valid = 1'b1;
        if (bus.DumpReady) state_nxt = (idx == IDX_LAST) ? DONE : DUMP_ADDR;
      end
`endif
      DONE: begin
        done = 1'b1;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET)                    drain_cnt <= '0;
    else if (state == RUN && halt) drain_cnt <= '0;
    else if (state == DRAIN)      drain_cnt <= drain_cnt + 1'b1;
  end

  // Counts RUN and DRAIN cycles, saturating so it never wraps back to 0.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET)
      cyc_cnt <= '0;
    else if ((state == RUN || state == DRAIN) && (cyc_cnt != {CYC_W{1'b1}}))
      cyc_cnt <= cyc_cnt + 1'b1;
  end

`ifdef DUMP_EN
  // MainMemory returns data one cycle after the address, so the word is
  // captured in DUMP_CAP and held unchanged through DUMP_OUT.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      idx        <= '0;
      dump_index <= '0;
      dump_data  <= '0;
    end else begin
      if (state == DUMP_CAP) begin
        dump_data  <= bus.MemReadData;
        dump_index <= idx;
      end
      if (state == DUMP_OUT && bus.DumpReady && idx != IDX_LAST)
        idx <= idx + 1'b1;
    end
  end

  assign bus.DumpAddr  = mem_owner ? idx : '0;
  assign bus.DumpData  = dump_data;
  assign bus.DumpIndex = dump_index;
`else
  logic unused_inputs;
  assign unused_inputs = ^{bus.DumpReady, bus.MemReadData};
  assign bus.DumpAddr  = '0;
  assign bus.DumpData  = '0;
  assign bus.DumpIndex = '0;
`endif

  assign bus.PCHold     = pc_hold;
  assign bus.FetchKill  = pc_hold;
  assign bus.PipeEN     = pipe_en;
  assign bus.MemOwner   = mem_owner;
  assign bus.DumpValid  = dump_valid;
  assign bus.Done       = done;
  assign bus.CycleCount = cyc_cnt;

endmodule

// File: tb/tb_halt_dump_ctrl.sv
// tb/tb_halt_dump_ctrl.sv - directed self-checking bench for halt_dump_ctrl
`timescale 1ns/1ps
module tb_halt_dump_ctrl;
  localparam int ADDR_W = 2;
  localparam int CYC_W  = 32;
  localparam int MEM_DEPTH = 4;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
  localparam logic [31:0] ADDI = 32'h0010_0093;
  localparam logic [31:0] BEQ  = 32'h0000_0463;
  localparam logic [31:0] BR_TGT = 32'd16;

  logic CLOCK = 1'b0;
  logic RESET = 1'b1;

  halt_dump_ctrl_if #(.ADDR_W(ADDR_W), .CYC_W(CYC_W)) bus ();

  halt_dump_ctrl #(
    .HALT_WORD(HALT), .DRAIN_CYCLES(4), .MEM_DEPTH(MEM_DEPTH),
    .ADDR_W(ADDR_W), .CYC_W(CYC_W)
  ) dut (
    .CLOCK(CLOCK),
    .RESET(RESET),
    .bus(bus)
  );

  always #5 CLOCK = ~CLOCK;

  logic [31:0] imem [0:15];
  logic [31:0] dmem [0:3];
  logic [31:0] pc, inst_d;
  int cyc = 0;

  // Minimal fetch/decode model: PC advances unless held, redirects on a
  // branch resolved in D, IF/ID loads a NOP when FetchKill is high.
  assign bus.Inst_F        = imem[pc[5:2]];
  assign bus.BranchTaken_D = (inst_d == BEQ);

  always @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      pc     <= 32'd0;
      inst_d <= 32'd0;
    end else begin
      if (!bus.PCHold) pc <= bus.BranchTaken_D ? BR_TGT : pc + 32'd4;
      inst_d <= bus.FetchKill ? 32'd0 : bus.Inst_F;
    end
  end

  always @(posedge CLOCK) bus.MemReadData <= dmem[bus.DumpAddr];

  always @(posedge CLOCK) begin
    if (RESET) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  int beat_cyc[$];
  int beat_idx[$];
  logic [31:0] beat_data[$];

  always @(posedge CLOCK) begin
    if (!RESET && bus.DumpValid && bus.DumpReady) begin
      beat_cyc.push_back(cyc);
      beat_idx.push_back(int'(bus.DumpIndex));
      beat_data.push_back(bus.DumpData);
    end
  end

  logic        ph_s [0:39];
  logic        fk_s [0:39];
  logic        pe_s [0:39];
  logic        mo_s [0:39];
  logic        dv_s [0:39];
  logic        dn_s [0:39];
  logic [31:0] cc_s [0:39];
  logic [31:0] pc_s [0:39];
  logic [31:0] dd_s [0:39];
  logic [31:0] di_s [0:39];

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic load_prog1();
    for (int i = 0; i < 16; i++) imem[i] = ADDI;
    imem[3] = HALT;
  endtask

  task automatic load_prog2();
    for (int i = 0; i < 16; i++) imem[i] = ADDI;
    imem[1] = BEQ;
    imem[2] = HALT;
    imem[5] = HALT;
  endtask

  // Reset, release at a falling edge (start of cycle 0), then sample each
  // cycle mid-low-phase; DumpReady is low for cycles stall_lo..stall_hi.
  task automatic do_run(input int ncyc, input int stall_lo, input int stall_hi);
    RESET = 1'b1;
    bus.DumpReady = 1'b1;
    beat_cyc.delete();
    beat_idx.delete();
    beat_data.delete();
    @(posedge CLOCK);
    @(negedge CLOCK);
    RESET = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      if (c > 0) @(negedge CLOCK);
      #1;
      bus.DumpReady = !(c >= stall_lo && c <= stall_hi);
      #1;
      ph_s[c] = bus.PCHold;
      fk_s[c] = bus.FetchKill;
      pe_s[c] = bus.PipeEN;
      mo_s[c] = bus.MemOwner;
      dv_s[c] = bus.DumpValid;
      dn_s[c] = bus.Done;
      cc_s[c] = bus.CycleCount;
      pc_s[c] = pc;
      dd_s[c] = bus.DumpData;
      di_s[c] = 32'(bus.DumpIndex);
    end
  endtask

  initial begin
    dmem[0] = 32'h11; dmem[1] = 32'h22; dmem[2] = 32'h33; dmem[3] = 32'h44;
    bus.DumpReady = 1'b1;

    // Reset values; halt word at PC 0 must not raise PCHold while in reset.
    for (int i = 0; i < 16; i++) imem[i] = HALT;
    #2;
    check("rst_pchold", 32'(bus.PCHold), 32'd0);
    check("rst_fetchkill", 32'(bus.FetchKill), 32'd0);
    check("rst_pipeen", 32'(bus.PipeEN), 32'd1);
    check("rst_memowner", 32'(bus.MemOwner), 32'd0);
    check("rst_dumpvalid", 32'(bus.DumpValid), 32'd0);
    check("rst_done", 32'(bus.Done), 32'd0);
    check("rst_cyclecount", bus.CycleCount, 32'd0);
    check("rst_dumpdata", bus.DumpData, 32'd0);
    check("rst_dumpindex", 32'(bus.DumpIndex), 32'd0);
    check("rst_dumpaddr", 32'(bus.DumpAddr), 32'd0);

    // Halt at PC=12 with DumpReady always high.
    load_prog1();
    do_run(26, 99, 99);
    for (int c = 0; c < 3; c++) check($sformatf("h1_pchold_c%0d", c), 32'(ph_s[c]), 32'd0);
    check("h1_pchold_c3", 32'(ph_s[3]), 32'd1);
    check("h1_fetchkill_c3", 32'(fk_s[3]), 32'd1);
    for (int c = 3; c < 8; c++) check($sformatf("h1_pipeen_c%0d", c), 32'(pe_s[c]), 32'd1);
    check("h1_pipeen_c8", 32'(pe_s[8]), 32'd0);
    check("h1_pc_c8", pc_s[8], 32'd12);
    check("h1_cc_c3", cc_s[3], 32'd3);
    check("h1_cc_c8", cc_s[8], 32'd8);
    check("h1_cc_c25", cc_s[25], 32'd8);
`ifdef DUMP_EN
    check("h1_memowner_c8", 32'(mo_s[8]), 32'd1);
    for (int c = 0; c < 26; c++) begin
      check($sformatf("d1_valid_c%0d", c), 32'(dv_s[c]),
            32'(c == 10 || c == 13 || c == 16 || c == 19));
      check($sformatf("d1_done_c%0d", c), 32'(dn_s[c]), 32'(c >= 20));
    end
    check("d1_nbeats", 32'(beat_cyc.size()), 32'd4);
    for (int i = 0; i < 4 && i < beat_cyc.size(); i++) begin
      check($sformatf("d1_beat%0d_cyc", i), 32'(beat_cyc[i]), 32'(10 + 3 * i));
      check($sformatf("d1_beat%0d_idx", i), 32'(beat_idx[i]), 32'(i));
      check($sformatf("d1_beat%0d_data", i), beat_data[i], dmem[i]);
    end

    // Backpressure on word 1 for five cycles.
    do_run(30, 13, 17);
    for (int c = 13; c <= 17; c++) begin
      check($sformatf("bp_valid_c%0d", c), 32'(dv_s[c]), 32'd1);
      check($sformatf("bp_data_c%0d", c), dd_s[c], 32'h22);
      check($sformatf("bp_index_c%0d", c), di_s[c], 32'd1);
    end
    check("bp_nbeats", 32'(beat_cyc.size()), 32'd4);
    for (int i = 0; i < 4 && i < beat_cyc.size(); i++) begin
      check($sformatf("bp_beat%0d_cyc", i), 32'(beat_cyc[i]), (i == 0) ? 32'd10 : 32'(15 + 3 * i));
      check($sformatf("bp_beat%0d_idx", i), 32'(beat_idx[i]), 32'(i));
      check($sformatf("bp_beat%0d_data", i), beat_data[i], dmem[i]);
    end
    check("bp_done_c24", 32'(dn_s[24]), 32'd0);
    check("bp_done_c25", 32'(dn_s[25]), 32'd1);
`else
    for (int c = 0; c < 26; c++) begin
      check($sformatf("nd_done_c%0d", c), 32'(dn_s[c]), 32'(c >= 8));
      check($sformatf("nd_valid_c%0d", c), 32'(dv_s[c]), 32'd0);
      check($sformatf("nd_memowner_c%0d", c), 32'(mo_s[c]), 32'd0);
    end
    check("nd_nbeats", 32'(beat_cyc.size()), 32'd0);
`endif

    // Wrong-path halt at PC=8 behind a taken branch to 16; real halt at 20.
    load_prog2();
    do_run(12, 99, 99);
    check("wp_pchold_c2", 32'(ph_s[2]), 32'd0);
    check("wp_pc_c3", pc_s[3], 32'd16);
    check("wp_pchold_c3", 32'(ph_s[3]), 32'd0);
    check("wp_pchold_c4", 32'(ph_s[4]), 32'd1);
    check("wp_pc_c8", pc_s[8], 32'd20);
    check("wp_cc_c11", cc_s[11], 32'd9);

    // Reset pulse while word 2 is stalled in DUMP_OUT (DONE without dump).
    load_prog1();
    do_run(18, 16, 99);
`ifdef DUMP_EN
    check("rp_valid_c17", 32'(dv_s[17]), 32'd1);
    check("rp_index_c17", di_s[17], 32'd2);
    check("rp_data_c17", dd_s[17], 32'h33);
    check("rp_memowner_c17", 32'(mo_s[17]), 32'd1);
`else
    check("rp_done_c17", 32'(dn_s[17]), 32'd1);
`endif
    #2;
    RESET = 1'b1;
    #1;
    check("rp_valid_rst", 32'(bus.DumpValid), 32'd0);
    check("rp_memowner_rst", 32'(bus.MemOwner), 32'd0);
    check("rp_cc_rst", bus.CycleCount, 32'd0);
    check("rp_done_rst", 32'(bus.Done), 32'd0);
    check("rp_pipeen_rst", 32'(bus.PipeEN), 32'd1);
    check("rp_index_rst", 32'(bus.DumpIndex), 32'd0);
    @(posedge CLOCK);
    @(negedge CLOCK);
    RESET = 1'b0;
    #1;
    check("rp_pc_c0", pc, 32'd0);
    check("rp_pchold_c0", 32'(bus.PCHold), 32'd0);
    repeat (3) @(negedge CLOCK);
    #1;
    check("rp_pc_c3", pc, 32'd12);
    check("rp_pchold_c3", 32'(bus.PCHold), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
